// File: rtl/mem_indirect_seq.sv
// mem_indirect_seq: sits between the LC-3b MEM stage (c_*) and the data memory port (p_*).
// Direct accesses pass straight through. Indirect accesses are expanded into a chain of
// pointer reads followed by the final read/write, and the result is held until the
// pipeline advances.
module mem_indirect_seq #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned MASK_W     = DATA_W / 8,
    parameter int unsigned MAX_LEVELS = 2,
    localparam int unsigned LVL_W     = $clog2(MAX_LEVELS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              indir,
    input  logic [LVL_W-1:0]  levels,
    input  logic              advance,
    input  logic              flush,
    input  logic              c_read,
    input  logic              c_write,
    input  logic [MASK_W-1:0] c_wmask,
    input  logic [ADDR_W-1:0] c_address,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_resp,
    output logic [DATA_W-1:0] c_rdata,
    output logic              p_read,
    output logic              p_write,
    output logic [MASK_W-1:0] p_wmask,
    output logic [ADDR_W-1:0] p_address,
    output logic [DATA_W-1:0] p_wdata,
    input  logic              p_resp,
    input  logic [DATA_W-1:0] p_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PTR   = 2'd1,
        S_FINAL = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [LVL_W-1:0]    remain_q, remain_d;
    logic [DATA_W-1:0]   hold_data_q, hold_data_d;
    logic                kill_q, kill_d;

    logic [LVL_W-1:0]    lvl_clamp;
    logic                chain_start;
    logic                kill_now;
    logic [ADDR_W-1:0]   fetched_ptr;

    // Requested depth saturated at MAX_LEVELS
    assign lvl_clamp   = (levels > LVL_W'(MAX_LEVELS)) ? LVL_W'(MAX_LEVELS) : levels;
    // An indirect op in IDLE starts a chain instead of passing through
    assign chain_start = indir & (c_read | c_write) & (levels != '0) & ~flush;
    // A flush seen now or earlier in this chain squashes the response
    assign kill_now    = kill_q | flush;
    assign fetched_ptr = p_rdata[ADDR_W-1:0];
    assign busy        = (state_q != S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Chain datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            remain_q    <= '0;
            hold_data_q <= '0;
            kill_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            remain_q    <= remain_d;
            hold_data_q <= hold_data_d;
            kill_q      <= kill_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        remain_d    = remain_q;
        hold_data_d = hold_data_q;
        kill_d      = kill_q;
        case (state_q)
            S_IDLE: begin
                if (chain_start) begin
                    if (p_resp) begin
                        ptr_d    = fetched_ptr;
                        remain_d = lvl_clamp - LVL_W'(1);
                        state_d  = (lvl_clamp == LVL_W'(1)) ? S_FINAL : S_PTR;
                    end else begin
                        // First pointer read still pending: ptr carries the CPU address
                        ptr_d    = c_address;
                        remain_d = lvl_clamp;
                        state_d  = S_PTR;
                    end
                end
            end
            S_PTR: begin
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (p_resp) begin
                    if (kill_now) begin
                        kill_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        ptr_d    = fetched_ptr;
                        remain_d = remain_q - LVL_W'(1);
                        if (remain_q == LVL_W'(1)) begin
                            state_d = S_FINAL;
                        end
                    end
                end
            end
            S_FINAL: begin
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (p_resp) begin
                    if (kill_now) begin
                        kill_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        hold_data_d = p_rdata;
                        state_d     = advance ? S_IDLE : S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (advance || !indir || flush) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Port drive per state; reset forces all requests/responses low
    always_comb begin
        p_read    = 1'b0;
        p_write   = 1'b0;
        p_wmask   = c_wmask;
        p_address = ptr_q;
        p_wdata   = c_wdata;
        c_resp    = 1'b0;
        c_rdata   = p_rdata;
        case (state_q)
            S_IDLE: begin
                p_address = c_address;
                if (chain_start) begin
                    p_read  = 1'b1;
                    p_wmask = '1;
                end else begin
                    p_read  = c_read;
                    p_write = c_write;
                    c_resp  = p_resp;
                end
            end
            S_PTR: begin
                p_read  = 1'b1;
                p_wmask = '1;
            end
            S_FINAL: begin
                p_read  = c_read;
                p_write = c_write;
                c_resp  = p_resp & ~kill_now;
            end
            S_HOLD: begin
                c_resp  = 1'b1;
                c_rdata = hold_data_q;
            end
            default: begin
                p_read = 1'b0;
            end
        endcase
        if (rst) begin
            p_read  = 1'b0;
            p_write = 1'b0;
            c_resp  = 1'b0;
        end
    end

    // The MEM stage never requests a read and a write together
    a_cpu_rw_excl: assert property (@(posedge clk) disable iff (rst) !(c_read && c_write));
    // At most one physical request type at a time
    a_phys_rw_excl: assert property (@(posedge clk) disable iff (rst) !(p_read && p_write));

endmodule

// File: tb/tb_mem_indirect_seq.sv
// Scoreboard bench for mem_indirect_seq with a latency-configurable memory model.
module tb_mem_indirect_seq;

    logic        clk;
    logic        rst;
    logic        indir;
    logic [1:0]  levels;
    logic        advance;
    logic        flush;
    logic        c_read;
    logic        c_write;
    logic [1:0]  c_wmask;
    logic [15:0] c_address;
    logic [15:0] c_wdata;
    logic        c_resp;
    logic [15:0] c_rdata;
    logic        p_read;
    logic        p_write;
    logic [1:0]  p_wmask;
    logic [15:0] p_address;
    logic [15:0] p_wdata;
    logic        p_resp;
    logic [15:0] p_rdata;
    logic        busy;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [1:0]  mask;
        logic [15:0] wdata;
    } phys_t;

    typedef struct {
        logic        chk;
        logic [15:0] data;
    } resp_t;

    phys_t phys_q[$];
    resp_t resp_q[$];
    int    checks;
    int    errors;
    int    lat;
    int    cnt;
    logic [15:0] mem [0:65535];

    mem_indirect_seq dut (
        .clk       (clk),
        .rst       (rst),
        .indir     (indir),
        .levels    (levels),
        .advance   (advance),
        .flush     (flush),
        .c_read    (c_read),
        .c_write   (c_write),
        .c_wmask   (c_wmask),
        .c_address (c_address),
        .c_wdata   (c_wdata),
        .c_resp    (c_resp),
        .c_rdata   (c_rdata),
        .p_read    (p_read),
        .p_write   (p_write),
        .p_wmask   (p_wmask),
        .p_address (p_address),
        .p_wdata   (p_wdata),
        .p_resp    (p_resp),
        .p_rdata   (p_rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers in the lat-th cycle of a held request (lat=1 means same cycle)
    assign p_resp  = (p_read || p_write) && (cnt == lat - 1);
    assign p_rdata = mem[p_address];

    initial begin : mem_model
        for (int i = 0; i < 65536; i++) mem[i] <= 16'h0000;
        mem[16'h3000] <= 16'h1234;
        mem[16'h4000] <= 16'hBEEF;
        mem[16'h5000] <= 16'h1100;
        mem[16'h6000] <= 16'h7777;
        cnt <= 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                cnt <= 0;
            end else if (p_read || p_write) begin
                if (p_resp) begin
                    cnt <= 0;
                    if (p_write) begin
                        for (int b = 0; b < 2; b++) begin
                            if (p_wmask[b]) mem[p_address][b*8 +: 8] <= p_wdata[b*8 +: 8];
                        end
                    end
                end else begin
                    cnt <= cnt + 1;
                end
            end
        end
    end

    // Physical-side monitor: every completed access must match the next expected one
    initial begin : phys_mon
        phys_t e;
        forever begin
            @(negedge clk);
            if (!rst && p_resp) begin
                checks++;
                if (phys_q.size() == 0) begin
                    errors++;
                    $display("FAIL phys_unexpected: rd=%b wr=%b addr=%h", p_read, p_write, p_address);
                end else begin
                    e = phys_q.pop_front();
                    if (p_write !== e.we || p_read !== !e.we || p_address !== e.addr ||
                        (e.we && (p_wmask !== e.mask || p_wdata !== e.wdata))) begin
                        errors++;
                        $display("FAIL phys_access: got rd=%b wr=%b addr=%h mask=%b wdata=%h, expected wr=%b addr=%h mask=%b wdata=%h",
                                 p_read, p_write, p_address, p_wmask, p_wdata, e.we, e.addr, e.mask, e.wdata);
                    end
                end
            end
        end
    end

    // CPU-side monitor: a new response pops the scoreboard, a held one must stay stable and idle the bus
    initial begin : resp_mon
        resp_t       e;
        logic        prev;
        logic [15:0] held;
        prev = 1'b0;
        held = 16'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (c_resp && !prev) begin
                    checks++;
                    if (resp_q.size() == 0) begin
                        errors++;
                        $display("FAIL resp_unexpected: c_rdata=%h", c_rdata);
                    end else begin
                        e = resp_q.pop_front();
                        held = e.chk ? e.data : c_rdata;
                        if (e.chk && c_rdata !== e.data) begin
                            errors++;
                            $display("FAIL resp_data: got %h expected %h", c_rdata, e.data);
                        end
                    end
                end else if (c_resp && prev) begin
                    checks++;
                    if (c_rdata !== held || p_read !== 1'b0 || p_write !== 1'b0) begin
                        errors++;
                        $display("FAIL hold_stable: got data=%h rd=%b wr=%b expected data=%h rd=0 wr=0",
                                 c_rdata, p_read, p_write, held);
                    end
                end
                prev = c_resp;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic exp_phys(input logic we, input logic [15:0] a, input logic [1:0] m, input logic [15:0] wd);
        phys_t p;
        p.we = we; p.addr = a; p.mask = m; p.wdata = wd;
        phys_q.push_back(p);
    endtask

    task automatic exp_resp(input logic chk, input logic [15:0] d);
        resp_t r;
        r.chk = chk; r.data = d;
        resp_q.push_back(r);
    endtask

    // Present one op, wait for c_resp, optionally stall hold_n cycles, then advance
    task automatic run_op(input string name, input logic ind, input logic [1:0] lv,
                          input logic rd, input logic wr, input logic [1:0] m,
                          input logic [15:0] a, input logic [15:0] wd,
                          input int hold_n, input int exp_lat);
        int n;
        indir = ind; levels = lv; c_read = rd; c_write = wr;
        c_wmask = m; c_address = a; c_wdata = wd; advance = 1'b0;
        #1;
        n = 0;
        while (!c_resp && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!c_resp) begin
            errors++;
            $display("FAIL %s_timeout: no c_resp within %0d cycles", name, n);
        end else if (n != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles expected %0d", name, n, exp_lat);
        end
        repeat (hold_n) begin
            @(posedge clk); #1;
        end
        advance = 1'b1;
        @(posedge clk); #1;
        advance = 1'b0; indir = 1'b0; c_read = 1'b0; c_write = 1'b0; flush = 1'b0;
        check({name, "_idle"}, 16'(busy), 16'h0);
        @(posedge clk); #1;
    endtask

    initial begin : stim
        checks = 0; errors = 0; lat = 1;
        rst = 1'b1; indir = 1'b0; levels = 2'd0; advance = 1'b0; flush = 1'b0;
        c_read = 1'b1; c_write = 1'b0; c_wmask = 2'b11; c_address = 16'h3000; c_wdata = 16'h0;

        // Reset overrides the pass-through
        repeat (2) @(posedge clk);
        #1;
        check("rst_p_read", 16'(p_read), 16'h0);
        check("rst_c_resp", 16'(c_resp), 16'h0);
        check("rst_busy",   16'(busy),   16'h0);
        c_read = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // T1: direct read, zero-latency pass-through
        lat = 1;
        exp_phys(1'b0, 16'h3000, 2'b11, 16'h0);
        exp_resp(1'b1, 16'h1234);
        run_op("t1", 1'b0, 2'd0, 1'b1, 1'b0, 2'b11, 16'h3000, 16'h0, 0, 0);

        // Direct write installs the pointer 0x3000 -> 0x4000
        exp_phys(1'b1, 16'h3000, 2'b11, 16'h4000);
        exp_resp(1'b0, 16'h0);
        run_op("wr_p1", 1'b0, 2'd0, 1'b0, 1'b1, 2'b11, 16'h3000, 16'h4000, 0, 0);

        // T2: LDI, one level, L=2
        lat = 2;
        exp_phys(1'b0, 16'h3000, 2'b11, 16'h0);
        exp_phys(1'b0, 16'h4000, 2'b11, 16'h0);
        exp_resp(1'b1, 16'hBEEF);
        run_op("t2", 1'b1, 2'd1, 1'b1, 1'b0, 2'b11, 16'h3000, 16'h0, 0, 3);

        // T5: same chain, result held three cycles before advance
        exp_phys(1'b0, 16'h3000, 2'b11, 16'h0);
        exp_phys(1'b0, 16'h4000, 2'b11, 16'h0);
        exp_resp(1'b1, 16'hBEEF);
        run_op("t5", 1'b1, 2'd1, 1'b1, 1'b0, 2'b11, 16'h3000, 16'h0, 3, 3);

        // T3: STI through 0x3000 -> 0x5000 with low-byte mask
        lat = 1;
        exp_phys(1'b1, 16'h3000, 2'b11, 16'h5000);
        exp_resp(1'b0, 16'h0);
        run_op("wr_p2", 1'b0, 2'd0, 1'b0, 1'b1, 2'b11, 16'h3000, 16'h5000, 0, 0);
        lat = 2;
        exp_phys(1'b0, 16'h3000, 2'b11, 16'h0);
        exp_phys(1'b1, 16'h5000, 2'b01, 16'h00AA);
        exp_resp(1'b0, 16'h0);
        run_op("t3", 1'b1, 2'd1, 1'b0, 1'b1, 2'b01, 16'h3000, 16'h00AA, 0, 3);
        lat = 1;
        exp_phys(1'b0, 16'h5000, 2'b11, 16'h0);
        exp_resp(1'b1, 16'h11AA);
        run_op("t3_rb", 1'b0, 2'd0, 1'b1, 1'b0, 2'b11, 16'h5000, 16'h0, 0, 0);

        // T4: two-level chain 0x3000 -> 0x4000 -> 0x6000
        exp_phys(1'b1, 16'h3000, 2'b11, 16'h4000);
        exp_resp(1'b0, 16'h0);
        run_op("wr_p3", 1'b0, 2'd0, 1'b0, 1'b1, 2'b11, 16'h3000, 16'h4000, 0, 0);
        exp_phys(1'b1, 16'h4000, 2'b11, 16'h6000);
        exp_resp(1'b0, 16'h0);
        run_op("wr_p4", 1'b0, 2'd0, 1'b0, 1'b1, 2'b11, 16'h4000, 16'h6000, 0, 0);
        exp_phys(1'b0, 16'h3000, 2'b11, 16'h0);
        exp_phys(1'b0, 16'h4000, 2'b11, 16'h0);
        exp_phys(1'b0, 16'h6000, 2'b11, 16'h0);
        exp_resp(1'b1, 16'h7777);
        run_op("t4_l2", 1'b1, 2'd2, 1'b1, 1'b0, 2'b11, 16'h3000, 16'h0, 0, 2);
        // levels=3 clamps to 2; L=2 gives 3 accesses of 2 cycles
        lat = 2;
        exp_phys(1'b0, 16'h3000, 2'b11, 16'h0);
        exp_phys(1'b0, 16'h4000, 2'b11, 16'h0);
        exp_phys(1'b0, 16'h6000, 2'b11, 16'h0);
        exp_resp(1'b1, 16'h7777);
        run_op("t4_l3", 1'b1, 2'd3, 1'b1, 1'b0, 2'b11, 16'h3000, 16'h0, 0, 5);

        // Flush in IDLE: indirect op just passes through
        lat = 1;
        flush = 1'b1;
        exp_phys(1'b0, 16'h3000, 2'b11, 16'h0);
        exp_resp(1'b1, 16'h4000);
        run_op("flush_idle", 1'b1, 2'd1, 1'b1, 1'b0, 2'b11, 16'h3000, 16'h0, 0, 0);

        // T6a: flush during a pointer read
        lat = 3;
        exp_phys(1'b0, 16'h3000, 2'b11, 16'h0);
        indir = 1'b1; levels = 2'd1; c_read = 1'b1; c_write = 1'b0; c_address = 16'h3000;
        @(posedge clk); #1;
        check("t6_busy", 16'(busy), 16'h1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; indir = 1'b0; c_read = 1'b0;
        #1;
        check("t6_held_rd",   16'(p_read), 16'h1);
        check("t6_held_addr", p_address,   16'h3000);
        @(posedge clk); #1;
        check("t6_idle",    16'(busy),   16'h0);
        check("t6_no_read", 16'(p_read), 16'h0);
        @(posedge clk); #1;

        // T6b: reset in the middle of a chain
        indir = 1'b1; levels = 2'd1; c_read = 1'b1; c_address = 16'h3000;
        @(posedge clk); #1;
        check("t6r_busy", 16'(busy), 16'h1);
        rst = 1'b1;
        #1;
        check("t6r_rd_forced", 16'(p_read), 16'h0);
        @(posedge clk); #1;
        rst = 1'b0; indir = 1'b0; c_read = 1'b0;
        #1;
        check("t6r_idle",  16'(busy),   16'h0);
        check("t6r_no_rd", 16'(p_read), 16'h0);
        repeat (2) @(posedge clk);
        #1;

        check("phys_q_empty", 16'(phys_q.size()), 16'h0);
        check("resp_q_empty", 16'(resp_q.size()), 16'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
